// File: rtl/video_pattern_gen.sv
// Streaming test-pattern source: frames of H_ACTIVE x V_ACTIVE beats with tuser/tlast framing.
// Define VIDEO_PATTERN_GEN_HBLANK_EN to insert H_BLANK idle cycles between lines of a frame.
module video_pattern_gen #(
  parameter int D_WIDTH  = 8,
  parameter int H_ACTIVE = 8,
  parameter int V_ACTIVE = 4,
  parameter int H_BLANK  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         pattern_sel,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready,
  output logic [7:0]         frame_cnt,
  output logic               frame_done
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  if (H_ACTIVE < 2 || V_ACTIVE < 2 || H_BLANK < 0 || D_WIDTH < 1 || D_WIDTH > 32) begin : g_bad_param
    $error("video_pattern_gen: unsupported parameter set");
  end

`ifdef VIDEO_PATTERN_GEN_HBLANK_EN
  localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(H_BLANK - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

  state_t             state, state_next;
  logic [XW-1:0]      x, x_next;
  logic [YW-1:0]      y, y_next;
  logic [1:0]         pat, pat_next;
  logic [7:0]         fc_next;
  logic [D_WIDTH-1:0] data_next;
  logic               valid_next, tlast_next, tuser_next, done_next;
  logic               load;
`ifdef VIDEO_PATTERN_GEN_HBLANK_EN
  logic [BW-1:0]      blank_cnt, blank_next;
`endif

  function automatic logic [D_WIDTH-1:0] pixel(input logic [1:0]    sel,
                                               input logic [XW-1:0] px,
                                               input logic [YW-1:0] py,
                                               input logic [7:0]    fc);
    logic [31:0] sum;
    sum = '0;
    case (sel)
      2'd0:    sum = 32'(px);
      2'd1:    sum = 32'(py);
      2'd2:    sum = (px[0] ^ py[0]) ? '1 : '0;
      default: sum = 32'(px) + 32'(py) + 32'(fc);
    endcase
    return sum[D_WIDTH-1:0];
  endfunction

  // Outputs are computed for the coordinates the beat will carry (x_next/y_next)
  // so every output leaves a flop; 'load' marks a new beat being presented.
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    pat_next   = pat;
    fc_next    = frame_cnt;
    data_next  = down_data;
    valid_next = down_valid;
    tlast_next = down_tlast;
    tuser_next = down_tuser;
    done_next  = 1'b0;
    load       = 1'b0;
`ifdef VIDEO_PATTERN_GEN_HBLANK_EN
    blank_next = blank_cnt;
`endif

    case (state)
      IDLE: begin
        if (enable) begin
          state_next = ACTIVE;
          x_next     = '0;
          y_next     = '0;
          pat_next   = pattern_sel;
          load       = 1'b1;
        end
      end

      ACTIVE: begin
        if (down_valid && down_ready) begin
          if (x == X_LAST) begin
            x_next = '0;
            if (y == Y_LAST) begin
              y_next    = '0;
              fc_next   = frame_cnt + 8'd1;
              done_next = 1'b1;
              if (enable) begin
                pat_next = pattern_sel;
                load     = 1'b1;
              end else begin
                state_next = IDLE;
                valid_next = 1'b0;
                tlast_next = 1'b0;
                tuser_next = 1'b0;
              end
            end else begin
              y_next = y + YW'(1);
`ifdef VIDEO_PATTERN_GEN_HBLANK_EN
              if (H_BLANK == 0) begin
                load = 1'b1;
              end else begin
                state_next = BLANK;
                blank_next = '0;
                valid_next = 1'b0;
                tlast_next = 1'b0;
              end
`else
              load = 1'b1;
`endif
            end
          end else begin
            x_next = x + XW'(1);
            load   = 1'b1;
          end
        end
      end

`ifdef VIDEO_PATTERN_GEN_HBLANK_EN
      BLANK: begin
        blank_next = blank_cnt + BW'(1);
        if (blank_cnt == B_LAST) begin
          state_next = ACTIVE;
          load       = 1'b1;
        end
      end
`endif

      default: state_next = IDLE;
    endcase

    if (load) begin
      valid_next = 1'b1;
      data_next  = pixel(pat_next, x_next, y_next, fc_next);
      tlast_next = (x_next == X_LAST);
      tuser_next = (x_next == '0) && (y_next == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      pat        <= '0;
      frame_cnt  <= '0;
      down_data  <= '0;
      down_valid <= 1'b0;
      down_tlast <= 1'b0;
      down_tuser <= 1'b0;
      frame_done <= 1'b0;
`ifdef VIDEO_PATTERN_GEN_HBLANK_EN
      blank_cnt  <= '0;
`endif
    end else begin
      state      <= state_next;
      x          <= x_next;
      y          <= y_next;
      pat        <= pat_next;
      frame_cnt  <= fc_next;
      down_data  <= data_next;
      down_valid <= valid_next;
      down_tlast <= tlast_next;
      down_tuser <= tuser_next;
      frame_done <= done_next;
`ifdef VIDEO_PATTERN_GEN_HBLANK_EN
      blank_cnt  <= blank_next;
`endif
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen (default 8x4 frame); blank-gap expectations follow
// VIDEO_PATTERN_GEN_HBLANK_EN.
module tb_video_pattern_gen;

`ifdef VIDEO_PATTERN_GEN_HBLANK_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       down_ready = 1'b1;
  logic [7:0] down_data;
  logic       down_valid, down_tlast, down_tuser;
  logic [7:0] frame_cnt;
  logic       frame_done;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .D_WIDTH (8),
    .H_ACTIVE(8),
    .V_ACTIVE(4),
    .H_BLANK (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pattern_sel(pattern_sel),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_tlast (down_tlast),
    .down_tuser (down_tuser),
    .down_ready (down_ready),
    .frame_cnt  (frame_cnt),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [7:0] data;
    logic       tlast;
    logic       tuser;
    logic       last;
    logic       chk_gap;
    int         gap;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    accepted = 0;
  bit    toggle_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_pix(input int sel, input int x, input int y, input int fc);
    case (sel)
      0:       return 8'(x);
      1:       return 8'(y);
      2:       return ((x + y) % 2 == 1) ? 8'hFF : 8'h00;
      default: return 8'((x + y + fc) % 256);
    endcase
  endfunction

  task automatic push_frame(input int sel, input int fc, input bit from_idle);
    beat_t b;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        b.data    = model_pix(sel, x, y, fc);
        b.tlast   = (x == 7);
        b.tuser   = (x == 0 && y == 0);
        b.last    = (x == 7 && y == 3);
        b.chk_gap = !(x == 0 && y == 0 && from_idle);
        b.gap     = (x == 0 && y != 0) ? GAP : 0;
        sb.push_back(b);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    down_ready = toggle_ready ? ~down_ready : 1'b1;
  endtask

  task automatic start_frame(input logic [1:0] sel);
    pattern_sel = sel;
    enable      = 1'b1;
    step();
    enable      = 1'b0;
    pattern_sel = sel ^ 2'b01;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check({"drain_", name}, sb.size(), 0);
    repeat (3) step();
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (accepted < target && n < budget) begin
      step();
      n++;
    end
    check("reach_beats", accepted, target);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each accepted beat.
  logic [7:0] pdata;
  logic       ptlast, ptuser, pstall, pend;
  int         lowcnt, mfc;

  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      pend   = 1'b0;
      pstall = 1'b0;
      mfc    = 0;
      lowcnt = 0;
    end else begin
      if (pend) mfc = (mfc + 1) % 256;
      check("frame_done", frame_done, pend);
      check("frame_cnt", frame_cnt, mfc);
      pend = 1'b0;
      if (pstall) begin
        check("stall_valid", down_valid, 1'b1);
        check("stall_data", down_data, pdata);
        check("stall_tlast", down_tlast, ptlast);
        check("stall_tuser", down_tuser, ptuser);
      end
      pstall = down_valid && !down_ready;
      pdata  = down_data;
      ptlast = down_tlast;
      ptuser = down_tuser;
      if (down_valid && down_ready) begin
        check("beat_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          b = sb.pop_front();
          check("data", down_data, b.data);
          check("tlast", down_tlast, b.tlast);
          check("tuser", down_tuser, b.tuser);
          if (b.chk_gap) check("gap", lowcnt, b.gap);
          pend = b.last;
        end
        accepted++;
        lowcnt = 0;
      end else if (!down_valid) begin
        lowcnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fc;
    int base;
    #2 rst = 1'b0;
    #20;
    check("rst_valid", down_valid, 1'b0);
    check("rst_tlast", down_tlast, 1'b0);
    check("rst_tuser", down_tuser, 1'b0);
    check("rst_data", down_data, 8'h00);
    check("rst_frame_cnt", frame_cnt, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    step();
    fc = 0;

    // Pattern 0, single frame, pattern_sel changed mid-frame must be ignored.
    push_frame(0, fc, 1'b1);
    start_frame(2'd0);
    wait_drain("p0", 200);
    fc++;
    check("p0_idle_valid", down_valid, 1'b0);
    check("p0_frame_cnt", frame_cnt, 8'd1);

    // Pattern 2 checkerboard.
    push_frame(2, fc, 1'b1);
    start_frame(2'd2);
    wait_drain("p2", 200);
    fc++;

    // Pattern 1 under alternating ready.
    toggle_ready = 1'b1;
    push_frame(1, fc, 1'b1);
    start_frame(2'd1);
    wait_drain("p1_bp", 300);
    toggle_ready = 1'b0;
    step();
    fc++;

    // Pattern 3 with enable held: two frames back-to-back, second uses incremented count.
    push_frame(3, fc, 1'b1);
    push_frame(3, fc + 1, 1'b0);
    base        = accepted;
    pattern_sel = 2'd3;
    enable      = 1'b1;
    wait_beats(base + 40, 200);
    enable = 1'b0;
    wait_drain("p3_b2b", 200);
    fc += 2;
    check("b2b_frame_cnt", frame_cnt, 8'(fc));

    // Enable dropped at beat 10: frame still completes, then idles.
    push_frame(0, fc, 1'b1);
    base        = accepted;
    pattern_sel = 2'd0;
    enable      = 1'b1;
    wait_beats(base + 10, 100);
    enable = 1'b0;
    wait_drain("en_drop", 200);
    fc++;
    repeat (4) step();
    check("en_drop_idle_valid", down_valid, 1'b0);
    check("en_drop_frame_cnt", frame_cnt, 8'(fc));

    // Reset at beat 12 abandons the frame.
    push_frame(0, fc, 1'b1);
    base = accepted;
    start_frame(2'd0);
    wait_beats(base + 12, 100);
    rst = 1'b0;
    #1;
    check("midrst_valid", down_valid, 1'b0);
    check("midrst_frame_cnt", frame_cnt, 8'h00);
    sb.delete();
    step();
    step();
    rst = 1'b1;
    step();
    fc = 0;
    push_frame(0, fc, 1'b1);
    start_frame(2'd0);
    wait_drain("after_rst", 200);
    check("after_rst_frame_cnt", frame_cnt, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, pixel data width.
REQ-002 The block SHALL have parameter H_ACTIVE, default 8, pixels per line (even, >=2).
REQ-003 The block SHALL have parameter V_ACTIVE, default 4, lines per frame (even, >=2).
REQ-004 The block SHALL have parameter H_BLANK, default 4, idle cycles after each line (used only with the macro in REQ-026).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1; one clock, reset asynchronous and active-low.
REQ-007 The block SHALL have port enable, input, 1, which requests frame generation.
REQ-008 The block SHALL have port pattern_sel, input, 2, which selects the pattern.
REQ-009 The block SHALL have port down_data, output, D_WIDTH, the pixel value.
REQ-010 The block SHALL have ports down_valid, down_tlast and down_tuser, output, 1 each: beat valid, end of line, start of frame.
REQ-011 The block SHALL have port down_ready, input, 1, the downstream accept.
REQ-012 The block SHALL have port frame_cnt, output, 8, the count of completed frames (wraps 255->0).
REQ-013 The block SHALL have port frame_done, output, 1, a one-cycle pulse on acceptance of the last beat of a frame.

Function
REQ-014 States SHALL be IDLE, ACTIVE and BLANK; BLANK exists only with the macro.
- IDLE->ACTIVE on enable=1.
- ACTIVE->BLANK on an accepted tlast that is not the last beat of the frame.
- BLANK->ACTIVE after H_BLANK cycles.
- ACTIVE->IDLE on acceptance of the last beat of the frame when enable=0.
- ACTIVE stays ACTIVE (new frame, x=y=0) on acceptance of the last beat of the frame when enable=1.
REQ-015 All outputs SHALL be registered; the first down_valid=1 appears the cycle after enable is sampled 1 in IDLE.
REQ-016 While down_valid=1 and down_ready=0, down_data, down_tlast and down_tuser SHALL hold stable.
REQ-017 A beat SHALL be accepted when down_valid=1 and down_ready=1; the next beat is presented the following cycle, so throughput is one beat per cycle under continuous ready.
REQ-018 Counters: x SHALL count 0..H_ACTIVE-1 and y SHALL count 0..V_ACTIVE-1; x wraps and y increments on an accepted tlast.
REQ-019 down_tuser SHALL be 1 only for the beat x=0,y=0; down_tlast SHALL be 1 only for beats with x=H_ACTIVE-1.
REQ-020 pattern_sel SHALL be sampled at frame start and held for the whole frame.
REQ-021 Pattern values, all truncated to D_WIDTH bits:
- 0: data=x.
- 1: data=y.
- 2: data=all-ones if x[0]^y[0], else 0.
- 3: data=x+y+frame_cnt.
REQ-022 enable deasserted mid-frame SHALL NOT truncate the frame; the frame completes.
REQ-023 frame_cnt SHALL increment and frame_done SHALL pulse in the same cycle as the accepting edge of the last beat.

Reset
REQ-024 rst=0 SHALL force, asynchronously:
- state to IDLE;
- x, y, frame_cnt and down_data to 0;
- down_valid, down_tlast, down_tuser and frame_done to 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the next frame starts at x=y=0 with tuser=1.

Configuration
REQ-026 Macro VIDEO_PATTERN_GEN_HBLANK_EN defined SHALL insert H_BLANK cycles of down_valid=0 after every accepted tlast except the frame's last; undefined SHALL mean no BLANK state, so lines are back-to-back.

Verification
REQ-027 Scenario 1, defaults, ready=1, enable=1 for one frame, pattern 0, macro off:
- stimulus: as stated;
- response: 32 beats with data 0..7 repeating;
- tuser on beat 0 only;
- tlast on beats 7, 15, 23 and 31;
- frame_done pulses once and frame_cnt=1.
REQ-028 Scenario 2, pattern 2:
- stimulus: one frame;
- response: line 0 is 00,FF,00,FF,...;
- line 1 is FF,00,...
REQ-029 Scenario 3, backpressure:
- stimulus: ready toggles 1,0,1,0 during pattern 1;
- response: no beat lost or duplicated;
- data is stable while ready=0;
- the sequence is 0x8,1x8,2x8,3x8.
REQ-030 Scenario 4, macro on with H_BLANK=4:
- stimulus: one frame;
- response: exactly 4 valid-low cycles after beats 7, 15 and 23;
- none after beat 31.
REQ-031 Scenario 5, enable drops mid-frame:
- stimulus: enable=0 at beat 10;
- response: the frame completes to beat 31, then IDLE with down_valid=0.
REQ-032 Scenario 6, reset mid-frame:
- stimulus: rst=0 at beat 12;
- response: down_valid=0 immediately;
- after release with enable=1 the first beat has tuser=1 and data=0;
- frame_cnt=0.
